// File: rtl/photon_counter_mc.sv
// Multi-channel gated photon pulse counter with double-buffered counts.
// Each closed gate yields one 64-bit record per channel toward a backpressured FIFO.
module photon_counter_mc #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned COUNT_W     = 32,
   parameter int unsigned GATE_W      = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [NUM_CH-1:0] photon,
   input  logic              tri_in,
   input  logic              mode_cont,
   input  logic              enable,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              fifo_full,
   output logic [63:0]       writedata,
   output logic              write,
   output logic              busy,
   output logic [23:0]       frame_cnt,
   output logic [15:0]       drop_cnt
);

   localparam int unsigned CH_W    = 4;
   localparam int unsigned FRAME_W = 24;
   localparam int unsigned DROP_W  = 16;
   localparam int unsigned IN_W    = NUM_CH + 1;
   localparam int unsigned CHAIN_W = SYNC_STAGES * IN_W;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic {IDLE, GATE} gate_state_t;
   typedef enum logic {D_IDLE, D_WRITE} drain_state_t;

   gate_state_t  gate_state, gate_nxt;
   drain_state_t drain_state, drain_nxt;

   logic [CHAIN_W-1:0] sync_q;
   logic [IN_W-1:0]    prev_q;
   logic [IN_W-1:0]    rise_c;
   logic [NUM_CH-1:0]  inc;

   logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_nxt;
   logic               eog, load;

   logic [COUNT_W-1:0] cnt_q   [NUM_CH];
   logic [COUNT_W-1:0] cnt_new [NUM_CH];
   logic               sat_q   [NUM_CH];
   logic               sat_new [NUM_CH];
   logic [COUNT_W-1:0] sh_cnt  [NUM_CH];
   logic               sh_sat  [NUM_CH];
   logic [FRAME_W-1:0] sh_frame;

   logic               shadow_full, shadow_full_nxt;
   logic               drop_pend, drop_pend_nxt;
   logic               accept, drop, last_wr;
   logic [CH_W-1:0]    ch_q, ch_nxt;
   logic [COUNT_W-1:0] rec_cnt;
   logic               rec_sat;
   logic [63:0]        rec;

   // Photon and trigger synchronisers share one shift chain; trigger is the MSB
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[CHAIN_W-IN_W-1:0], tri_in, photon};
         prev_q <= sync_q[CHAIN_W-1 -: IN_W];
      end
   end

   assign rise_c = sync_q[CHAIN_W-1 -: IN_W] & ~prev_q;
   assign inc    = rise_c[NUM_CH-1:0] & {NUM_CH{gate_state == GATE}};

   always_comb begin
      gate_nxt     = gate_state;
      gate_cnt_nxt = gate_cnt_q;
      eog          = 1'b0;
      load         = 1'b0;
      case (gate_state)
         IDLE: begin
            if (enable && (mode_cont || rise_c[NUM_CH])) begin
               gate_nxt = GATE;
               load     = 1'b1;
            end
         end
         GATE: begin
            gate_cnt_nxt = gate_cnt_q - GATE_W'(1);
            if (gate_cnt_q == GATE_W'(1)) begin
               eog = 1'b1;
               if (mode_cont && enable) load = 1'b1;
               else gate_nxt = IDLE;
            end
         end
         default: gate_nxt = IDLE;
      endcase
      if (load) gate_cnt_nxt = (gate_len == '0) ? GATE_W'(1) : gate_len;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         gate_state <= IDLE;
         gate_cnt_q <= '0;
      end else begin
         gate_state <= gate_nxt;
         gate_cnt_q <= gate_cnt_nxt;
      end
   end

   // Saturating increment; a lost edge at full scale marks the frame
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_new[c] = cnt_q[c];
         sat_new[c] = sat_q[c];
         if (inc[c]) begin
            if (&cnt_q[c]) sat_new[c] = 1'b1;
            else cnt_new[c] = cnt_q[c] + COUNT_W'(1);
         end
      end
   end

   // The shadow may be refilled on the very cycle its last record leaves
   assign last_wr         = write && (ch_q == LAST_CH);
   assign accept          = eog && (!shadow_full || last_wr);
   assign drop            = eog && !accept;
   assign shadow_full_nxt = accept || (shadow_full && !last_wr);
   assign drop_pend_nxt   = drop || (drop_pend && !last_wr);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]  <= '0;
            sat_q[c]  <= 1'b0;
            sh_cnt[c] <= '0;
            sh_sat[c] <= 1'b0;
         end
         sh_frame    <= '0;
         shadow_full <= 1'b0;
         drop_pend   <= 1'b0;
         frame_cnt   <= '0;
         drop_cnt    <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= eog ? '0 : cnt_new[c];
            sat_q[c] <= eog ? 1'b0 : sat_new[c];
            if (accept) begin
               sh_cnt[c] <= cnt_new[c];
               sh_sat[c] <= sat_new[c];
            end
         end
         if (accept) sh_frame <= frame_cnt;
         if (eog) frame_cnt <= frame_cnt + FRAME_W'(1);
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
         shadow_full <= shadow_full_nxt;
         drop_pend   <= drop_pend_nxt;
      end
   end

   // Drain walks the shadow one channel per accepted FIFO slot
   always_comb begin
      drain_nxt = drain_state;
      ch_nxt    = ch_q;
      write     = 1'b0;
      case (drain_state)
         D_IDLE: begin
            if (shadow_full) begin
               drain_nxt = D_WRITE;
               ch_nxt    = '0;
            end
         end
         D_WRITE: begin
            if (!fifo_full) begin
               write = 1'b1;
               if (ch_q == LAST_CH) drain_nxt = D_IDLE;
               else ch_nxt = ch_q + CH_W'(1);
            end
         end
         default: drain_nxt = D_IDLE;
      endcase
   end

   always_comb begin
      rec_cnt = '0;
      rec_sat = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_nxt == CH_W'(c)) begin
            rec_cnt = sh_cnt[c];
            rec_sat = sh_sat[c];
         end
      end
      rec = {ch_nxt, rec_sat, drop_pend_nxt, 2'b00, sh_frame, 32'(rec_cnt)};
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         drain_state <= D_IDLE;
         ch_q        <= '0;
         writedata   <= '0;
         busy        <= 1'b0;
      end else begin
         drain_state <= drain_nxt;
         ch_q        <= ch_nxt;
         writedata   <= (drain_nxt == D_WRITE) ? rec : '0;
         busy        <= (gate_nxt == GATE) || shadow_full_nxt;
      end
   end

endmodule

// File: tb/tb_photon_counter_mc.sv
// Directed bench for photon_counter_mc: records are scoreboarded as frames are stimulated.
module tb_photon_counter_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  photon;
   logic        tri_in, mode_cont, enable, fifo_full;
   logic [23:0] gate_len;
   logic [63:0] wd, wd8;
   logic        wr, wr8, busy, busy8;
   logic [23:0] fc, fc8;
   logic [15:0] dc, dc8;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   logic [63:0] q32[$];
   logic [63:0] q8[$];
   longint wtimes[$];

   always #5 clk = ~clk;

   photon_counter_mc #(.NUM_CH(4), .COUNT_W(32), .GATE_W(24), .SYNC_STAGES(2)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .photon(photon), .tri_in(tri_in),
      .mode_cont(mode_cont), .enable(enable), .gate_len(gate_len), .fifo_full(fifo_full),
      .writedata(wd), .write(wr), .busy(busy), .frame_cnt(fc), .drop_cnt(dc));

   photon_counter_mc #(.NUM_CH(4), .COUNT_W(8), .GATE_W(24), .SYNC_STAGES(2)) dut8 (
      .clk_clk(clk), .reset_reset_n(rst_n), .photon(photon), .tri_in(tri_in),
      .mode_cont(mode_cont), .enable(enable), .gate_len(gate_len), .fifo_full(fifo_full),
      .writedata(wd8), .write(wr8), .busy(busy8), .frame_cnt(fc8), .drop_cnt(dc8));

   function automatic logic [63:0] mk_rec(input int ch, input int cnt, input bit c8,
                                          input bit drop, input int frame);
      logic [31:0] v;
      bit s;
      if (c8 && cnt > 255) begin v = 32'd255; s = 1'b1; end
      else begin v = 32'(cnt); s = 1'b0; end
      return {4'(ch), s, drop, 2'b00, 24'(frame), v};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int c0, input int c1, input int c2, input int c3,
                             input bit drop, input int frame);
      int n[4];
      n = '{c0, c1, c2, c3};
      for (int c = 0; c < 4; c++) begin
         q32.push_back(mk_rec(c, n[c], 1'b0, drop, frame));
         q8.push_back(mk_rec(c, n[c], 1'b1, drop, frame));
      end
   endtask

   // Channel c receives n_c pulses, one per two cycles, all channels in parallel
   task automatic pulse_train(input int c0, input int c1, input int c2, input int c3);
      int n[4];
      int mx;
      n = '{c0, c1, c2, c3};
      mx = 0;
      for (int c = 0; c < 4; c++) if (n[c] > mx) mx = n[c];
      for (int i = 0; i < mx; i++) begin
         for (int c = 0; c < 4; c++) photon[c] = (i < n[c]);
         tick();
         photon = '0;
         tick();
      end
   endtask

   task automatic trigger();
      tri_in = 1'b1;
      tick();
      tri_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      photon = '0; tri_in = 1'b0; mode_cont = 1'b0; enable = 1'b1; fifo_full = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         done = (q32.size() == 0) && (q8.size() == 0) && (busy === 1'b0) && (busy8 === 1'b0);
      end
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL %s drain timeout busy=%0b pending=%0d expected idle/0", tag, busy, q32.size());
      end
   endtask

   task automatic monitor();
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (wr === 1'b1) begin
            wr_seen++;
            wtimes.push_back($time);
            chk("wr_while_full", 64'(fifo_full), 64'd0);
            checks++;
            assert (q32.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_write got %h expected none", wd);
            end
            if (q32.size() != 0) begin
               e = q32.pop_front();
               chk("rec32", wd, e);
            end
         end
         if (wr8 === 1'b1) begin
            checks++;
            assert (q8.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_write8 got %h expected none", wd8);
            end
            if (q8.size() != 0) begin
               e = q8.pop_front();
               chk("rec8", wd8, e);
            end
         end
      end
   endtask

   initial begin
      int base;
      bit hit;
      rst_n = 1'b0; photon = '0; tri_in = 1'b0; mode_cont = 1'b0;
      enable = 1'b1; fifo_full = 1'b0; gate_len = 24'd100;
      fork monitor(); join_none

      // Reset state
      #12;
      chk("rst_wd", wd, 64'd0);
      chk("rst_wr", 64'(wr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fc", 64'(fc), 64'd0);
      chk("rst_dc", 64'(dc), 64'd0);
      do_reset();

      // 1: basic triggered frame
      gate_len = 24'd100;
      push_frame(5, 10, 15, 20, 1'b0, 0);
      trigger();
      repeat (3) tick();
      chk("t1_busy", 64'(busy), 64'd1);
      pulse_train(5, 10, 15, 20);
      wait_done("t1", 300);
      chk("t1_fc", 64'(fc), 64'd1);
      chk("t1_dc", 64'(dc), 64'd0);

      // 2a: edge on last gate cycle counted, next one lost in triggered mode
      do_reset();
      gate_len = 24'd10;
      push_frame(0, 1, 0, 0, 1'b0, 0);
      trigger();
      repeat (9) tick();
      photon[1] = 1'b1;
      tick();
      photon[1] = 1'b0; photon[2] = 1'b1;
      tick();
      photon[2] = 1'b0;
      wait_done("t2a", 100);
      chk("t2a_fc", 64'(fc), 64'd1);

      // 2b: continuous mode, the later edge opens frame 1
      do_reset();
      gate_len = 24'd10;
      push_frame(0, 1, 0, 0, 1'b0, 0);
      push_frame(0, 0, 1, 0, 1'b0, 1);
      mode_cont = 1'b1;
      repeat (8) tick();
      photon[1] = 1'b1;
      tick();
      photon[1] = 1'b0; photon[2] = 1'b1;
      tick();
      photon[2] = 1'b0;
      repeat (2) tick();
      mode_cont = 1'b0;
      wait_done("t2b", 100);
      chk("t2b_fc", 64'(fc), 64'd2);

      // 3: backpressure holds the record, then a back-to-back burst
      do_reset();
      gate_len = 24'd20;
      fifo_full = 1'b1;
      push_frame(1, 2, 3, 4, 1'b0, 0);
      trigger();
      pulse_train(1, 2, 3, 4);
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("t3_wr_held", 64'(wr), 64'd0);
         if (i >= 20) chk("t3_wd_hold", wd, mk_rec(0, 1, 1'b0, 1'b0, 0));
      end
      chk("t3_busy", 64'(busy), 64'd1);
      wtimes.delete();
      fifo_full = 1'b0;
      wait_done("t3", 50);
      chk("t3_nwr", 64'(wtimes.size()), 64'd4);
      if (wtimes.size() == 4) chk("t3_span", 64'(wtimes[3] - wtimes[0]), 64'd30);

      // 4: continuous short gates while the FIFO is blocked -> drops
      do_reset();
      gate_len = 24'd3;
      push_frame(1, 0, 0, 0, 1'b1, 0);
      mode_cont = 1'b1; fifo_full = 1'b1; photon[0] = 1'b1;
      tick();
      photon[0] = 1'b0;
      repeat (14) tick();
      mode_cont = 1'b0;
      repeat (5) tick();
      chk("t4_dc", 64'(dc), 64'd4);
      chk("t4_fc", 64'(fc), 64'd5);
      chk("t4_wr_held", 64'(wr), 64'd0);
      fifo_full = 1'b0;
      wait_done("t4", 50);
      chk("t4_dc_after", 64'(dc), 64'd4);

      // 5: saturation on the 8-bit instance
      do_reset();
      gate_len = 24'd700;
      push_frame(300, 0, 0, 0, 1'b0, 0);
      trigger();
      pulse_train(300, 0, 0, 0);
      wait_done("t5", 300);
      chk("t5_fc8", 64'(fc8), 64'd1);

      // 6: reset mid-drain
      do_reset();
      gate_len = 24'd10;
      push_frame(1, 1, 2, 2, 1'b0, 0);
      base = wr_seen;
      trigger();
      pulse_train(1, 1, 2, 2);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         #1;
         hit = (wr_seen >= base + 2);
      end
      chk("t6_two_writes", 64'(wr_seen - base), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("t6_wr", 64'(wr), 64'd0);
      chk("t6_wd", wd, 64'd0);
      chk("t6_fc", 64'(fc), 64'd0);
      chk("t6_dc", 64'(dc), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      q32.delete();
      q8.delete();
      base = wr_seen;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      chk("t6_no_writes", 64'(wr_seen - base), 64'd0);
      chk("t6_fc_after", 64'(fc), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
